packet_read_transmit: RTL

- Host-transmit-side counterpart of the receive-side packet writer.
- Accepts a descriptor (bufid, byte length) of a packet already stored in packet RAM.
- Reads the packet back as 134-bit words and serializes it to the 9-bit byte stream toward the host/network interface.
- Returns the bufid to the free-bufid pool after the last byte.

---
 rtl/packet_read_transmit_if.sv | 32 +++
 rtl/packet_read_transmit.sv | 85 ++++++++
 2 files changed

// File: rtl/packet_read_transmit_if.sv
// packet_read_transmit_if: descriptor, packet-RAM read, byte stream and bufid release signals
interface packet_read_transmit_if;
  logic [8:0] iv_pkt_bufid;
  logic [10:0] iv_pkt_len;
  logic i_descriptor_wr;
  logic o_descriptor_ack;
  logic [15:0] ov_rd_addr;
  logic o_rd_req;
  logic i_rd_ack;
  logic [133:0] iv_rdata;
  logic i_rdata_valid;
  logic [8:0] ov_data;
  logic o_data_wr;
  logic i_data_ready;
  logic [8:0] ov_bufid;
  logic o_bufid_wr;
  logic i_bufid_ack;
  logic o_pkt_out_pulse;
  logic o_format_error_pulse;
  modport master (
    input iv_pkt_bufid, iv_pkt_len, i_descriptor_wr, i_rd_ack, iv_rdata, i_rdata_valid,
    input i_data_ready, i_bufid_ack,
    output o_descriptor_ack, ov_rd_addr, o_rd_req, ov_data, o_data_wr, ov_bufid, o_bufid_wr,
    output o_pkt_out_pulse, o_format_error_pulse
  );
  modport slave (
    output iv_pkt_bufid, iv_pkt_len, i_descriptor_wr, i_rd_ack, iv_rdata, i_rdata_valid,
    output i_data_ready, i_bufid_ack,
    input o_descriptor_ack, ov_rd_addr, o_rd_req, ov_data, o_data_wr, ov_bufid, o_bufid_wr,
    input o_pkt_out_pulse, o_format_error_pulse
  );
endinterface

// File: rtl/packet_read_transmit.sv
// packet_read_transmit: reads a stored packet word by word and serializes it as a byte stream
module packet_read_transmit #(
  parameter bit BYTE_FLAG_EN = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  packet_read_transmit_if.master bus,
  output logic [2:0] prt_state
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SEND, RELEASE} state_t;
  state_t state, state_nxt;
  logic [8:0] bufid;
  logic [10:0] len, bytes_left;
  logic [6:0] word_idx;
  logic [3:0] byte_idx;
  logic [127:0] word;
  logic err_seen;
  logic accept, latch, xfer, first_byte, last_byte, last_word, flag_bad, unused_rsvd;
  assign accept = state == IDLE && bus.i_descriptor_wr;
  assign latch = state == RD_WAIT && bus.i_rdata_valid;
  assign xfer = state == SEND && bus.i_data_ready;
  assign first_byte = word_idx == 7'd0 && byte_idx == 4'd0;
  assign last_byte = bytes_left == 11'd1;
  assign last_word = word_idx == 7'((len - 11'd1) >> 4);
  // expected flag is {is_last_word, is_first_word}, covering head/tail/single/middle
  assign flag_bad = bus.iv_rdata[133:132] != {last_word, word_idx == 7'd0};
  assign unused_rsvd = ^bus.iv_rdata[131:128];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_descriptor_wr) state_nxt = bus.iv_pkt_len == 11'd0 ? RELEASE : RD_REQ;
      RD_REQ:  if (bus.i_rd_ack) state_nxt = RD_WAIT;
      RD_WAIT: if (bus.i_rdata_valid) state_nxt = SEND;
      SEND:    if (bus.i_data_ready) state_nxt = last_byte ? RELEASE : byte_idx == 4'd15 ? RD_REQ : SEND;
      RELEASE: if (bus.i_bufid_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.o_rd_req = state == RD_REQ;
    bus.ov_rd_addr = {bufid, word_idx};
    bus.o_data_wr = state == SEND;
    bus.ov_data = state == SEND ? {BYTE_FLAG_EN && (first_byte || last_byte), word[{~byte_idx, 3'b000} +: 8]} : 9'd0;
    bus.o_bufid_wr = state == RELEASE;
    bus.ov_bufid = bufid;
    prt_state = state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      bufid <= '0;
      len <= '0;
      bytes_left <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word <= '0;
      err_seen <= 1'b0;
      bus.o_descriptor_ack <= 1'b0;
      bus.o_format_error_pulse <= 1'b0;
      bus.o_pkt_out_pulse <= 1'b0;
    end else begin
      if (accept) begin
        bufid <= bus.iv_pkt_bufid;
        len <= bus.iv_pkt_len;
        bytes_left <= bus.iv_pkt_len;
        word_idx <= '0;
        err_seen <= bus.iv_pkt_len == 11'd0;
      end
      if (latch) begin
        word <= bus.iv_rdata[127:0];
        byte_idx <= '0;
        if (flag_bad) err_seen <= 1'b1;
      end
      if (xfer) begin
        byte_idx <= byte_idx + 4'd1;
        bytes_left <= bytes_left - 11'd1;
        if (byte_idx == 4'd15 && !last_byte) word_idx <= word_idx + 7'd1;
      end
      bus.o_descriptor_ack <= accept;
      bus.o_format_error_pulse <= (accept && bus.iv_pkt_len == 11'd0) || (latch && flag_bad && !err_seen);
      bus.o_pkt_out_pulse <= state == RELEASE && bus.i_bufid_ack && len != 11'd0;
    end
endmodule
